// File: rtl/writeback_unit_pkg.sv
// Shared register-file geometry and writeback FIFO helpers.
// Used by both the register file and the writeback unit.
package writeback_unit_pkg;

    localparam int REG_W      = 16;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_DEPTH   = 4;

    // Encoding is {push1, push0} so a raw cast from the two push strobes works.
    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_ALU  = 2'b10,
        SRC_BOTH = 2'b11
    } push_sel_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: up to two pushes (port 0 first) and one pop per cycle.
// Head outputs read as zero when the queue is empty.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0_i,
    input  logic [ADDR_W-1:0]        push0_addr_i,
    input  logic [WIDTH-1:0]         push0_data_i,
    input  logic                     push1_i,
    input  logic [ADDR_W-1:0]        push1_addr_i,
    input  logic [WIDTH-1:0]         push1_data_i,
    input  logic                     pop_i,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [WIDTH-1:0]         head_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             pop;
    push_sel_e        sel;

    assign empty = (count_q == '0);
    assign pop   = pop_i && !empty;
    assign sel   = push_sel_e'({push1_i, push0_i});

    always_comb begin
        wr_ptr_p1 = wr_ptr_q + 1'b1;
        wr_ptr_d  = wr_ptr_q;
        unique case (sel)
            SRC_MEM,
            SRC_ALU:  wr_ptr_d = wr_ptr_p1;
            SRC_BOTH: wr_ptr_d = wr_ptr_q + PTR_W'(2);
            default:  wr_ptr_d = wr_ptr_q;
        endcase
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When both arrive together the load result takes the earlier slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            unique case (sel)
                SRC_MEM: begin
                    addr_q[wr_ptr_q] <= push0_addr_i;
                    data_q[wr_ptr_q] <= push0_data_i;
                end
                SRC_ALU: begin
                    addr_q[wr_ptr_q] <= push1_addr_i;
                    data_q[wr_ptr_q] <= push1_data_i;
                end
                SRC_BOTH: begin
                    addr_q[wr_ptr_q]  <= push0_addr_i;
                    data_q[wr_ptr_q]  <= push0_data_i;
                    addr_q[wr_ptr_p1] <= push1_addr_i;
                    data_q[wr_ptr_p1] <= push1_data_i;
                end
                default: ;
            endcase
        end
    end

    assign head_addr_o = empty ? '0 : addr_q[rd_ptr_q];
    assign head_data_o = empty ? '0 : data_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file write master: merges load and ALU results into one write per cycle
// and tracks which destinations still have a write in flight.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [WIDTH-1:0]       mem_data,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_addr,
    input  logic [WIDTH-1:0]       alu_data,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_addr,
    output logic [2**ADDR_W-1:0]   pending,
    output logic                   writeEnable,
    output logic [ADDR_W-1:0]      writeAddr,
    output logic [WIDTH-1:0]       d
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int NREG  = 2**ADDR_W;
    localparam logic [CNT_W-1:0] MEM_MAX = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ALU_MAX = CNT_W'(DEPTH - 2);

    logic [CNT_W-1:0] count;
    logic             mem_push;
    logic             alu_push;
    logic [NREG-1:0]  pending_q, pending_d;

    // Readiness looks only at the registered count; a same-cycle pop is not credited.
    assign mem_ready = (count <= MEM_MAX);
    assign alu_ready = (count <= ALU_MAX) || ((count == MEM_MAX) && !mem_valid);

    assign mem_push = mem_valid && mem_ready;
    assign alu_push = alu_valid && alu_ready;

    assign writeEnable = (count != '0);

    wb_fifo #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push0_i      (mem_push),
        .push0_addr_i (mem_addr),
        .push0_data_i (mem_data),
        .push1_i      (alu_push),
        .push1_addr_i (alu_addr),
        .push1_data_i (alu_data),
        .pop_i        (writeEnable),
        .head_addr_o  (writeAddr),
        .head_data_o  (d),
        .count_o      (count)
    );

    // A new issue to the register being committed keeps its bit set.
    always_comb begin
        pending_d = pending_q;
        if (writeEnable) begin
            pending_d[writeAddr] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule
